pac_move_ctrl: RTL and testbench

- Sequences the Pac-Man sprite position register that feeds the VGA sprite overlay (PacX/PacY).
- Arbitrates move requests from the on-board keypad and the PS2 keyboard.
- Holds at most one queued request and animates each accepted move as 1-pixel steps, one step per `tick` strobe.
- Clamps the sprite to the visible 640x480 area. A 32x32 sprite therefore has a maximum origin of 608/448.

---
 rtl/pac_pkg.sv | 48 ++++
 rtl/pac_req_decode.sv | 54 +++++
 rtl/pac_move_ctrl.sv | 156 +++++++++++++++
 tb/tb_pac_move_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pac_pkg.sv
// Shared types and constants for the Pac-Man sprite movement controller:
// direction encoding, input code tables and screen geometry.
package pac_pkg;

  typedef enum logic [1:0] {
    LEFT  = 2'd0,
    RIGHT = 2'd1,
    UP    = 2'd2,
    DOWN  = 2'd3
  } dir_t;

  typedef enum logic {
    SRC_KEYPAD,
    SRC_PS2
  } src_t;

  typedef enum logic {
    IDLE,
    MOVE
  } state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPRITE_W = 32;
  localparam int SPRITE_H = 32;
  localparam int X_MAX_DEF = SCREEN_W - SPRITE_W;
  localparam int Y_MAX_DEF = SCREEN_H - SPRITE_H;

  // Keypad codes are 5 bits wide; they are held zero-extended to 8 bits here.
  localparam logic [7:0] KEY_LEFT  = 8'h0C;
  localparam logic [7:0] KEY_RIGHT = 8'h0E;
  localparam logic [7:0] KEY_UP    = 8'h09;
  localparam logic [7:0] KEY_DOWN  = 8'h11;

  localparam logic [7:0] PS2_LEFT  = 8'h6B;
  localparam logic [7:0] PS2_RIGHT = 8'h74;
  localparam logic [7:0] PS2_UP    = 8'h75;
  localparam logic [7:0] PS2_DOWN  = 8'h72;

  function automatic logic is_horiz(dir_t d);
    return (d == LEFT) || (d == RIGHT);
  endfunction

  function automatic logic is_decr(dir_t d);
    return (d == LEFT) || (d == UP);
  endfunction

endpackage

// File: rtl/pac_req_decode.sv
// Rising-edge detector on one input source's ready level plus decoding of its
// code into a direction. req_valid is high only in the cycle of the edge.
module pac_req_decode
  import pac_pkg::*;
#(
  parameter src_t SRC    = SRC_KEYPAD,
  parameter int   CODE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ready,
  input  logic [CODE_W-1:0] code,
  output logic              req_valid,
  output dir_t              req_dir
);

  logic       ready_q;
  logic       known;
  logic [7:0] code8;

  assign code8 = 8'(code);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= ready;
  end

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    known   = 1'b1;
    req_dir = RIGHT;
    if (SRC == SRC_KEYPAD) begin
      case (code8)
        KEY_LEFT:  req_dir = LEFT;
        KEY_RIGHT: req_dir = RIGHT;
        KEY_UP:    req_dir = UP;
        KEY_DOWN:  req_dir = DOWN;
        default:   known   = 1'b0;
      endcase
    end else begin
      case (code8)
        PS2_LEFT:  req_dir = LEFT;
        PS2_RIGHT: req_dir = RIGHT;
        PS2_UP:    req_dir = UP;
        PS2_DOWN:  req_dir = DOWN;
        default:   known   = 1'b0;
      endcase
    end
  end

  // Unknown codes never become requests, so they are neither queued nor counted.
  assign req_valid = ready & ~ready_q & known;

endmodule

// File: rtl/pac_move_ctrl.sv
// Sprite position sequencer: arbitrates keypad/PS2 move requests through a
// one-deep queue and walks the sprite one pixel per tick toward a clamped target.
module pac_move_ctrl
  import pac_pkg::*;
#(
  parameter int X_INIT = 30,
  parameter int Y_INIT = 146,
  parameter int STEP   = 20,
  parameter int X_MAX  = X_MAX_DEF,
  parameter int Y_MAX  = Y_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       key_ready,
  input  logic [4:0] key_code,
  input  logic       ps2_ready,
  input  logic [7:0] ps2_code,
  output logic [9:0] pos_x,
  output logic [8:0] pos_y,
  output logic [1:0] dir,
  output logic       moving,
  output logic       pending,
  output logic [7:0] drop_cnt
);

  // Target = cur +/- STEP in 11-bit signed, clamped to [0, max].
  function automatic logic [9:0] step_target(logic [9:0] cur, logic dec, int max);
    logic signed [10:0] t;
    if (dec) t = $signed({1'b0, cur}) - $signed(11'(STEP));
    else     t = $signed({1'b0, cur}) + $signed(11'(STEP));
    if (t < 11'sd0)                  return '0;
    else if (t > $signed(11'(max)))  return 10'(max);
    else                             return t[9:0];
  endfunction

  state_t     state;
  dir_t       dir_q, q_dir;
  logic [9:0] target;

  logic       k_valid, p_valid;
  dir_t       k_dir, p_dir;
  logic       first_v, second_v;
  dir_t       first_d;

  logic       start, use_first, slot_full, sel_horiz;
  dir_t       sel_dir, slot_dir;
  logic [1:0] drops;
  logic [8:0] drop_sum;
  logic [9:0] sel_cur, tgt, mv_cur, step_val;

  pac_req_decode #(.SRC(SRC_KEYPAD), .CODE_W(5)) u_key_dec (
    .clk(clk), .rst(rst), .ready(key_ready), .code(key_code),
    .req_valid(k_valid), .req_dir(k_dir)
  );

  pac_req_decode #(.SRC(SRC_PS2), .CODE_W(8)) u_ps2_dec (
    .clk(clk), .rst(rst), .ready(ps2_ready), .code(ps2_code),
    .req_valid(p_valid), .req_dir(p_dir)
  );

  // Keypad wins a same-cycle tie; the PS2 request then queues as the later one.
  assign first_v  = k_valid | p_valid;
  assign first_d  = k_valid ? k_dir : p_dir;
  assign second_v = k_valid & p_valid;

  always_comb begin
    start     = 1'b0;
    use_first = 1'b1;
    sel_dir   = q_dir;
    slot_full = pending;
    slot_dir  = q_dir;
    drops     = 2'd0;
    if (state == IDLE) begin
      if (pending) begin
        start     = 1'b1;
        slot_full = 1'b0;
      end else if (first_v) begin
        start     = 1'b1;
        sel_dir   = first_d;
        use_first = 1'b0;
      end
    end
    // The oldest request keeps the slot; anything arriving on a full slot is dropped.
    if (first_v && use_first) begin
      if (!slot_full) begin
        slot_full = 1'b1;
        slot_dir  = first_d;
      end else begin
        drops = drops + 2'd1;
      end
    end
    if (second_v) begin
      if (!slot_full) begin
        slot_full = 1'b1;
        slot_dir  = p_dir;
      end else begin
        drops = drops + 2'd1;
      end
    end
  end

  assign sel_horiz = is_horiz(sel_dir);
  assign sel_cur   = sel_horiz ? pos_x : {1'b0, pos_y};
  assign tgt       = step_target(sel_cur, is_decr(sel_dir), sel_horiz ? X_MAX : Y_MAX);

  assign mv_cur    = is_horiz(dir_q) ? pos_x : {1'b0, pos_y};
  assign step_val  = is_decr(dir_q) ? mv_cur - 10'd1 : mv_cur + 10'd1;

  assign drop_sum  = {1'b0, drop_cnt} + 9'(drops);
  assign dir       = dir_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pos_x    <= 10'(X_INIT);
      pos_y    <= 9'(Y_INIT);
      dir_q    <= RIGHT;
      q_dir    <= RIGHT;
      target   <= '0;
      moving   <= 1'b0;
      pending  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      pending  <= slot_full;
      q_dir    <= slot_dir;
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      case (state)
        IDLE: begin
          if (start) begin
            dir_q  <= sel_dir;
            target <= tgt;
            // Against the wall: direction still updates, but no motion starts.
            if (tgt != sel_cur) begin
              state  <= MOVE;
              moving <= 1'b1;
            end
          end
        end
        MOVE: begin
          if (tick) begin
            if (is_horiz(dir_q)) pos_x <= step_val;
            else                 pos_y <= step_val[8:0];
            if (step_val == target) begin
              state  <= IDLE;
              moving <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pac_move_ctrl.sv
// Bench for pac_move_ctrl: decode table, directed multi-cycle sequences and
// random traffic, all compared against a queue-based behavioural model.
module tb_pac_move_ctrl;
  import pac_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       key_ready;
  logic [4:0] key_code;
  logic       ps2_ready;
  logic [7:0] ps2_code;
  logic [9:0] pos_x;
  logic [8:0] pos_y;
  logic [1:0] dir;
  logic       moving;
  logic       pending;
  logic [7:0] drop_cnt;

  always #5 clk = ~clk;

  pac_move_ctrl #(
    .X_INIT(30), .Y_INIT(146), .STEP(20), .X_MAX(608), .Y_MAX(448)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .key_ready(key_ready), .key_code(key_code),
    .ps2_ready(ps2_ready), .ps2_code(ps2_code),
    .pos_x(pos_x), .pos_y(pos_y), .dir(dir),
    .moving(moving), .pending(pending), .drop_cnt(drop_cnt)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: position, remaining steps and a list-based queue.
  int m_x, m_y, m_dir, m_steps, m_drop;
  bit m_mv, m_pk, m_pp;
  int m_q[$];

  function automatic int kdec(int c);
    case (c)
      'h0C: return 0;
      'h0E: return 1;
      'h09: return 2;
      'h11: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int pdec(int c);
    case (c)
      'h6B: return 0;
      'h74: return 1;
      'h75: return 2;
      'h72: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_x = 30; m_y = 146; m_dir = 1; m_steps = 0; m_drop = 0;
    m_mv = 0; m_pk = 0; m_pp = 0;
    m_q.delete();
  endtask

  task automatic model_start(int d);
    int cur, lim, nv;
    m_dir = d;
    cur = (d < 2) ? m_x : m_y;
    lim = (d < 2) ? 608 : 448;
    nv  = (d == 0 || d == 2) ? cur - 20 : cur + 20;
    if (nv < 0)   nv = 0;
    if (nv > lim) nv = lim;
    m_steps = (nv > cur) ? nv - cur : cur - nv;
    m_mv = (m_steps > 0);
  endtask

  task automatic model_step(bit kr, int kc, bit pr, int pc, bit tk);
    int reqs[$];
    if (kr && !m_pk && kdec(kc) >= 0) reqs.push_back(kdec(kc));
    if (pr && !m_pp && pdec(pc) >= 0) reqs.push_back(pdec(pc));
    m_pk = kr;
    m_pp = pr;
    if (m_mv) begin
      if (tk) begin
        case (m_dir)
          0: m_x--;
          1: m_x++;
          2: m_y--;
          default: m_y++;
        endcase
        m_steps--;
        if (m_steps == 0) m_mv = 0;
      end
    end else if (m_q.size() > 0) begin
      model_start(m_q.pop_front());
    end else if (reqs.size() > 0) begin
      model_start(reqs.pop_front());
    end
    foreach (reqs[i]) begin
      if (m_q.size() == 0) m_q.push_back(reqs[i]);
      else if (m_drop < 255) m_drop++;
    end
  endtask

  task automatic compare_model();
    check("pos_x", int'(pos_x), m_x);
    check("pos_y", int'(pos_y), m_y);
    check("dir", int'(dir), m_dir);
    check("moving", int'(moving), int'(m_mv));
    check("pending", int'(pending), (m_q.size() > 0) ? 1 : 0);
    check("drop_cnt", int'(drop_cnt), m_drop);
  endtask

  task automatic cycle(bit kr, int kc, bit pr, int pc, bit tk);
    key_ready = kr; key_code = 5'(kc);
    ps2_ready = pr; ps2_code = 8'(pc);
    tick = tk;
    @(posedge clk);
    model_step(kr, kc, pr, pc, tk);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    key_ready = 0; key_code = 0; ps2_ready = 0; ps2_code = 0; tick = 0;
    repeat (2) @(posedge clk);
    model_reset();
    #1 rst = 1'b0;
    compare_model();
  endtask

  task automatic run_until_idle(string name);
    for (int i = 0; i < 100; i++) begin
      if (!moving) break;
      cycle(0, 0, 0, 0, 1);
    end
    check({name, "_done"}, int'(moving), 0);
  endtask

  typedef struct {
    bit src_ps2;
    int code;
    bit exp_mv;
    int exp_dir;
  } dec_vec_t;

  dec_vec_t tbl[12];
  int kpool[6] = '{'h0C, 'h0E, 'h09, 'h11, 'h1F, 'h03};
  int ppool[6] = '{'h6B, 'h74, 'h75, 'h72, 'h55, 'h00};

  initial begin
    int cnt;
    bit kr, pr;
    int kc, pc;

    tbl[0]  = '{0, 'h0C, 1, 0};
    tbl[1]  = '{0, 'h0E, 1, 1};
    tbl[2]  = '{0, 'h09, 1, 2};
    tbl[3]  = '{0, 'h11, 1, 3};
    tbl[4]  = '{0, 'h1F, 0, 1};
    tbl[5]  = '{0, 'h0B, 0, 1};
    tbl[6]  = '{1, 'h6B, 1, 0};
    tbl[7]  = '{1, 'h74, 1, 1};
    tbl[8]  = '{1, 'h75, 1, 2};
    tbl[9]  = '{1, 'h72, 1, 3};
    tbl[10] = '{1, 'h55, 0, 1};
    tbl[11] = '{1, 'h0E, 0, 1};

    rst = 1'b1;
    do_reset();
    check("reset_pos_x", int'(pos_x), 30);
    check("reset_pos_y", int'(pos_y), 146);
    check("reset_dir", int'(dir), 1);

    // Decode table: one edge from reset, look at moving/dir one clk later.
    foreach (tbl[i]) begin
      do_reset();
      if (tbl[i].src_ps2) cycle(0, 0, 1, tbl[i].code, 0);
      else                cycle(1, tbl[i].code, 0, 0, 0);
      check("dec_moving", int'(moving), int'(tbl[i].exp_mv));
      check("dec_dir", int'(dir), tbl[i].exp_dir);
      cycle(0, 0, 0, 0, 0);
    end

    // Plain RIGHT move: 20 ticks, 30 -> 50.
    do_reset();
    cycle(1, 'h0E, 0, 0, 0);
    check("s1_moving_rise", int'(moving), 1);
    check("s1_pos_before_tick", int'(pos_x), 30);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 1);
    check("s1_pos_x", int'(pos_x), 50);
    check("s1_moving_fall", int'(moving), 0);
    check("s1_pos_y", int'(pos_y), 146);

    // Same-cycle keypad LEFT + PS2 DOWN.
    do_reset();
    cycle(1, 'h0C, 1, 'h72, 0);
    check("s2_pending", int'(pending), 1);
    check("s2_dir_left", int'(dir), 0);
    run_until_idle("s2_left");
    check("s2_pos_x", int'(pos_x), 10);
    check("s2_pending_between", int'(pending), 1);
    cycle(0, 0, 0, 0, 0);
    check("s2_dir_down", int'(dir), 3);
    run_until_idle("s2_down");
    check("s2_pos_y", int'(pos_y), 166);
    check("s2_drop", int'(drop_cnt), 0);

    // Queue one, drop one during MOVE.
    do_reset();
    cycle(1, 'h0C, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 1, 'h74, 1);
    cycle(1, 'h09, 0, 0, 1);
    check("s3_drop", int'(drop_cnt), 1);
    run_until_idle("s3_left");
    cycle(0, 0, 0, 0, 0);
    run_until_idle("s3_right");
    check("s3_pos_x", int'(pos_x), 30);
    check("s3_pos_y", int'(pos_y), 146);

    // Clamp at the left wall.
    do_reset();
    cycle(1, 'h0C, 0, 0, 0);
    run_until_idle("s4_a");
    cycle(1, 'h0C, 0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 100 && moving; i++) begin
      cycle(1, 'h0C, 0, 0, 1);
      cnt++;
    end
    check("s4_clamp_ticks", cnt, 10);
    check("s4_pos_x", int'(pos_x), 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 'h0C, 0, 0, 1);
    check("s4_wall_moving", int'(moving), 0);
    check("s4_wall_dir", int'(dir), 0);
    cycle(0, 0, 0, 0, 1);
    check("s4_wall_pos", int'(pos_x), 0);

    // Unknown codes, then a held ready level.
    cycle(1, 'h1F, 1, 'h55, 1);
    check("s5_unknown_moving", int'(moving), 0);
    check("s5_unknown_pending", int'(pending), 0);
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 40; i++) cycle(1, 'h0E, 0, 0, 1);
    check("s5_held_pos_x", int'(pos_x), 20);
    check("s5_held_drop", int'(drop_cnt), 0);
    cycle(0, 0, 0, 0, 1);

    // Asynchronous reset mid-move with a queued request.
    do_reset();
    cycle(1, 'h0E, 0, 0, 0);
    cycle(0, 0, 1, 'h72, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);
    #2 rst = 1'b1;
    #1;
    check("s6_rst_pos_x", int'(pos_x), 30);
    check("s6_rst_pos_y", int'(pos_y), 146);
    check("s6_rst_moving", int'(moving), 0);
    check("s6_rst_pending", int'(pending), 0);
    key_ready = 0; ps2_ready = 0; tick = 0;
    @(posedge clk);
    model_reset();
    #1 rst = 1'b0;
    for (int i = 0; i < 25; i++) cycle(0, 0, 0, 0, 1);
    check("s6_after_pos_x", int'(pos_x), 30);
    check("s6_after_pos_y", int'(pos_y), 146);

    // Random traffic, including saturation of drop_cnt and wall clamps.
    do_reset();
    kr = 0; pr = 0; kc = 'h0E; pc = 'h74;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) kr = ~kr;
      if ($urandom_range(0, 2) == 0) pr = ~pr;
      if (!kr) kc = kpool[$urandom_range(0, 5)];
      if (!pr) pc = ppool[$urandom_range(0, 5)];
      cycle(kr, kc, pr, pc, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
